shiftregout_seq: RTL and testbench
==================================

// Module: shiftregout_seq
// PURPOSE
//  Readout sequencer for the perceptron output shift register (shiftregout).
//  On start it strobes a parallel load of the N DSP results, then walks the two
//  read ports (addr1/addr2) pair by pair, captures out1/out2 after a fixed read
//  latency and presents each pair downstream on a valid/ready stream.
//  Sits between the DSP array's result register and the next layer / host interface.
// PARAMETERS
//  B       24  word width of one perceptron result
//  N       40  number of perceptrons (entries in shiftregout); 2..63
//  AW      6   address width of addr1/addr2
//  RD_LAT  1   cycles from address presented to out1/out2 valid; 0, 1 or 2
// PORTS
//  clk      in   1    single clock, rising edge
//  rst      in   1    synchronous, active-high reset
//  start    in   1    begin one readout; sampled only in IDLE
//  order    in   1    sampled with start: 0=ascending pairs, 1=mirrored pairs
//  sr_load  out  1    1-cycle parallel-load strobe to shiftregout (ins -> regs)
//  sr_mode  out  1    mode to shiftregout; 0 (parallel/addressed) throughout
//  sr_addr1 out  AW   read address port 1
//  sr_addr2 out  AW   read address port 2
//  sr_out1  in   B    read data port 1
//  sr_out2  in   B    read data port 2
//  m_valid  out  1    downstream pair valid
//  m_ready  in   1    downstream accepts pair
//  m_data1  out  B    word at sr_addr1
//  m_data2  out  B    word at sr_addr2; 0 when m_single
//  m_single out  1    pair holds one word only (odd N, final beat)
//  m_last   out  1    final beat of this readout
//  busy     out  1    high from LOAD through DONE
//  done     out  1    1-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pair index 0. rst wins over every other input.
//  FSM: IDLE -> LOAD -> ISSUE -> WAIT -> HOLD -> (ISSUE | DONE) -> IDLE.
//   IDLE : start=1 latches order, next LOAD; start ignored in every other state.
//   LOAD : sr_load=1 for exactly this cycle; busy=1 from here; next ISSUE.
//   ISSUE: sr_addr1/2 driven for pair k (registered, stable until capture).
//          RD_LAT=0: capture sr_out1/2 at this edge, next HOLD; else next WAIT.
//   WAIT : counter runs RD_LAT-1 cycles; capture at edge ending cycle
//          issue+RD_LAT; next HOLD.
//   HOLD : m_valid=1; m_data1/2, m_single, m_last stable while m_ready=0.
//          On m_valid&&m_ready: m_valid drops next cycle; if m_last -> DONE,
//          else k+1 and ISSUE.
//   DONE : done=1 one cycle, busy=1; next IDLE (busy=0).
//  Pairs: P = ceil(N/2) beats, k = 0..P-1.
//   order=0: addr1=2k, addr2=2k+1.
//   order=1: addr1=k,  addr2=N-1-k.
//   Odd N final beat: addr2=addr1, m_single=1, m_data2=0.
//   m_last=1 only on beat P-1.
//  Throughput: one beat per RD_LAT+2 cycles with m_ready held high.
//  Latency: start edge -> first m_valid = 3+RD_LAT cycles.
//  sr_addr1/2 return to 0 in IDLE. sr_mode held 0.
//  Reset mid-readout: next cycle IDLE, m_valid=0, done not pulsed;
//   next start reloads and restarts at k=0.
//  m_ready asserted without m_valid has no effect.
// TESTING
//  N=40, RD_LAT=1, order=0, ins=100*(i+1), m_ready=1 -> 20 beats
//   (100,200),(300,400)..(3900,4000); m_last on beat 19; done 1 cycle later.
//  order=1, same data -> beats (100,4000),(200,3900)..(2000,2100);
//   addr pairs (0,39)..(19,20).
//  m_ready low 5 cycles at beat 3 -> m_data (700,800) and addresses stable;
//   no beat lost or duplicated.
//  N=5, order=1 -> (0,4),(1,3), then (2,2) with m_single=1, m_data2=0, m_last=1.
//  rst high 1 cycle after beat 7 accepted -> all outputs 0 next cycle, no done;
//   new start gives sr_load then beat 0 again.
//  start pulsed during HOLD -> ignored, sequence unchanged.
//  Repeat beat-count/ordering checks with RD_LAT=0 and 2: latency 3+RD_LAT.

Source files
------------

// File: rtl/shiftregout_seq_if.sv
// rtl/shiftregout_seq_if.sv - downstream pair stream of the shiftregout readout sequencer
interface shiftregout_seq_if #(
  parameter int B = 24
);
  logic         m_valid;
  logic         m_ready;
  logic [B-1:0] m_data1;
  logic [B-1:0] m_data2;
  logic         m_single;
  logic         m_last;

  modport master (
    output m_valid, m_data1, m_data2, m_single, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data1, m_data2, m_single, m_last,
    output m_ready
  );
endinterface

// File: rtl/shiftregout_seq.sv
// rtl/shiftregout_seq.sv - readout sequencer for the perceptron output shift register
// Loads shiftregout, walks its two read ports pair by pair and streams each pair downstream.
module shiftregout_seq #(
  parameter int B      = 24,
  parameter int N      = 40,
  parameter int AW     = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              order,
  output logic              sr_load,
  output logic              sr_mode,
  output logic [AW-1:0]     sr_addr1,
  output logic [AW-1:0]     sr_addr2,
  input  logic [B-1:0]      sr_out1,
  input  logic [B-1:0]      sr_out2,
  shiftregout_seq_if.master m,
  output logic              busy,
  output logic              done
);

  localparam int P   = (N + 1) / 2;
  localparam bit ODD = (N % 2) == 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_HOLD, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] k;
  logic          ord;
  logic [1:0]    wcnt;
  logic          k_last;
  logic          accept;
  logic          capture;
  logic          advance;
  logic [AW-1:0] nxt_k;
  logic [AW-1:0] nxt_a1, nxt_a2;

  // Address pair for beat kk; an odd final beat reads the same entry on both ports.
  function automatic logic [2*AW-1:0] pair_addr(input logic [AW-1:0] kk, input logic o);
    int a1;
    int a2;
    if (o) begin
      a1 = int'(kk);
      a2 = N - 1 - int'(kk);
    end else begin
      a1 = 2 * int'(kk);
      a2 = a1 + 1;
    end
    if (ODD && int'(kk) == P - 1) a2 = a1;
    return {AW'(a2), AW'(a1)};
  endfunction

  assign sr_mode = 1'b0;
  assign k_last  = (int'(k) == P - 1);
  assign accept  = (state == S_HOLD) && m.m_ready;
  assign advance = accept && !k_last;
  assign capture = ((state == S_ISSUE) && (RD_LAT == 0)) ||
                   ((state == S_WAIT) && (int'(wcnt) == RD_LAT - 1));
  assign nxt_k   = (state == S_LOAD) ? '0 : k + 1'b1;
  assign {nxt_a2, nxt_a1} = pair_addr(nxt_k, ord);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    sr_load   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    m.m_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_LOAD;
      end
      S_LOAD: begin
        sr_load = 1'b1;
        state_n = S_ISSUE;
      end
      S_ISSUE: state_n = (RD_LAT == 0) ? S_HOLD : S_WAIT;
      S_WAIT:  if (capture) state_n = S_HOLD;
      S_HOLD: begin
        m.m_valid = 1'b1;
        if (m.m_ready) state_n = k_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      ord        <= 1'b0;
      wcnt       <= '0;
      sr_addr1   <= '0;
      sr_addr2   <= '0;
      m.m_data1  <= '0;
      m.m_data2  <= '0;
      m.m_single <= 1'b0;
      m.m_last   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) ord <= order;

      if (state == S_LOAD)  k <= '0;
      else if (advance)     k <= k + 1'b1;

      // Addresses are set up one cycle ahead so they are stable for the whole ISSUE..HOLD span.
      if (state == S_LOAD || advance) begin
        sr_addr1 <= nxt_a1;
        sr_addr2 <= nxt_a2;
      end else if (accept) begin
        sr_addr1 <= '0;
        sr_addr2 <= '0;
      end

      wcnt <= (state == S_WAIT) ? wcnt + 2'd1 : 2'd0;

      if (capture) begin
        m.m_data1  <= sr_out1;
        m.m_data2  <= (ODD && k_last) ? '0 : sr_out2;
        m.m_single <= ODD && k_last;
        m.m_last   <= k_last;
      end
    end
  end

endmodule

// File: tb/tb_shiftregout_seq.sv
// tb/tb_shiftregout_seq.sv - directed bench for shiftregout_seq across N and read-latency variants
module tb_shiftregout_seq;
  localparam int B    = 24;
  localparam int AW   = 6;
  localparam int NCFG = 4;

  function automatic int cfg_n(input int g);
    return (g == 3) ? 5 : 40;
  endfunction

  function automatic int cfg_lat(input int g);
    case (g)
      1:       return 0;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0] rst, start, order_r, m_ready;
  logic [NCFG-1:0] load_w, mode_w, valid_w, single_w, last_w, busy_w, done_w;
  logic [AW-1:0]   a1_w [NCFG];
  logic [AW-1:0]   a2_w [NCFG];
  logic [B-1:0]    d1_w [NCFG];
  logic [B-1:0]    d2_w [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : gi
    localparam int NN = cfg_n(g);
    localparam int LL = cfg_lat(g);
    shiftregout_seq_if #(.B(B)) bus ();
    logic [AW-1:0] a1, a2;
    logic [B-1:0]  o1, o2, q1, q2, qq1, qq2;
    logic          ld, md, bsy, dn;
    logic [B-1:0]  regs [64];

    shiftregout_seq #(.B(B), .N(NN), .AW(AW), .RD_LAT(LL)) dut (
      .clk(clk), .rst(rst[g]), .start(start[g]), .order(order_r[g]),
      .sr_load(ld), .sr_mode(md), .sr_addr1(a1), .sr_addr2(a2),
      .sr_out1(o1), .sr_out2(o2), .m(bus), .busy(bsy), .done(dn)
    );

    // shiftregout model: parallel load of ins = 100*(i+1), reads with RD_LAT pipeline
    always_ff @(posedge clk) begin
      for (int i = 0; i < 64; i++) begin
        if (rst[g])  regs[i] <= '0;
        else if (ld) regs[i] <= (i < NN) ? B'(100 * (i + 1)) : '0;
      end
      q1  <= regs[a1];
      q2  <= regs[a2];
      qq1 <= q1;
      qq2 <= q2;
    end
    assign o1 = (LL == 0) ? regs[a1] : (LL == 1) ? q1 : qq1;
    assign o2 = (LL == 0) ? regs[a2] : (LL == 1) ? q2 : qq2;

    assign bus.m_ready = m_ready[g];
    assign load_w[g]   = ld;
    assign mode_w[g]   = md;
    assign busy_w[g]   = bsy;
    assign done_w[g]   = dn;
    assign valid_w[g]  = bus.m_valid;
    assign single_w[g] = bus.m_single;
    assign last_w[g]   = bus.m_last;
    assign a1_w[g]     = a1;
    assign a2_w[g]     = a2;
    assign d1_w[g]     = bus.m_data1;
    assign d2_w[g]     = bus.m_data2;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int cap_a1 [64];
  int cap_a2 [64];
  int cap_d1 [64];
  int cap_d2 [64];
  int cap_s  [64];
  int cap_l  [64];
  int acc_cyc[64];
  int nbeats, lat, done_cyc, load_cyc, nload;

  // One readout on config g; optional stall of stall_len cycles at stall_beat and a
  // stray start pulse while beat start_beat is presented.
  task automatic run(input int g, input int ord, input int stall_beat, input int stall_len,
                     input int start_beat);
    int cyc, stalled, s1, s2, sd1, sd2;
    bit seen_done;
    nbeats = 0; lat = -1; done_cyc = -1; load_cyc = -1; nload = 0;
    stalled = 0; seen_done = 0; cyc = 0;
    s1 = 0; s2 = 0; sd1 = 0; sd2 = 0;
    @(negedge clk);
    start[g] = 1'b1; order_r[g] = ord[0]; m_ready[g] = 1'b1;
    while (!seen_done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start[g]   = 1'b0;
      order_r[g] = ~ord[0];
      m_ready[g] = 1'b1;
      if (load_w[g]) begin nload++; load_cyc = cyc; end
      if (done_w[g]) begin seen_done = 1; done_cyc = cyc; end
      if (valid_w[g]) begin
        if (lat < 0) begin
          lat = cyc;
          chk($sformatf("cfg%0d sr_mode", g), mode_w[g], 0);
        end
        if (nbeats == start_beat) start[g] = 1'b1;
        if (nbeats == stall_beat && stalled < stall_len) begin
          m_ready[g] = 1'b0;
          if (stalled == 0) begin
            s1 = a1_w[g]; s2 = a2_w[g]; sd1 = d1_w[g]; sd2 = d2_w[g];
          end else begin
            chk("stall addr1", a1_w[g], s1);
            chk("stall addr2", a2_w[g], s2);
            chk("stall data1", d1_w[g], sd1);
            chk("stall data2", d2_w[g], sd2);
          end
          stalled++;
        end else if (nbeats < 64) begin
          cap_a1[nbeats] = a1_w[g]; cap_a2[nbeats] = a2_w[g];
          cap_d1[nbeats] = d1_w[g]; cap_d2[nbeats] = d2_w[g];
          cap_s[nbeats]  = single_w[g]; cap_l[nbeats] = last_w[g];
          acc_cyc[nbeats] = cyc;
          nbeats++;
        end
      end
    end
    @(negedge clk);
    chk($sformatf("cfg%0d busy after done", g), busy_w[g], 0);
    chk($sformatf("cfg%0d done width", g), done_w[g], 0);
    chk($sformatf("cfg%0d load count", g), nload, 1);
    chk($sformatf("cfg%0d load cycle", g), load_cyc, 1);
    chk($sformatf("cfg%0d done after last", g), done_cyc,
        (nbeats > 0) ? acc_cyc[nbeats-1] + 1 : -2);
  endtask

  task automatic check_beats(input int g, input int ord, input bit check_gap);
    int n, p, e1, e2, s;
    n = cfg_n(g);
    p = (n + 1) / 2;
    chk($sformatf("cfg%0d o%0d beat count", g, ord), nbeats, p);
    for (int k = 0; k < p && k < nbeats; k++) begin
      if (ord != 0) begin e1 = k; e2 = n - 1 - k; end
      else          begin e1 = 2 * k; e2 = 2 * k + 1; end
      s = ((n % 2) == 1 && k == p - 1) ? 1 : 0;
      if (s != 0) e2 = e1;
      chk($sformatf("cfg%0d o%0d b%0d addr1", g, ord, k), cap_a1[k], e1);
      chk($sformatf("cfg%0d o%0d b%0d addr2", g, ord, k), cap_a2[k], e2);
      chk($sformatf("cfg%0d o%0d b%0d data1", g, ord, k), cap_d1[k], 100 * (e1 + 1));
      chk($sformatf("cfg%0d o%0d b%0d data2", g, ord, k), cap_d2[k], (s != 0) ? 0 : 100 * (e2 + 1));
      chk($sformatf("cfg%0d o%0d b%0d single", g, ord, k), cap_s[k], s);
      chk($sformatf("cfg%0d o%0d b%0d last", g, ord, k), cap_l[k], (k == p - 1) ? 1 : 0);
      if (check_gap && k > 0)
        chk($sformatf("cfg%0d o%0d b%0d interval", g, ord, k), acc_cyc[k] - acc_cyc[k-1],
            cfg_lat(g) + 2);
    end
  endtask

  typedef struct {
    int g; int ord; int beat;
    int a1; int a2; int d1; int d2; int s; int l;
    int nb; int lat;
  } vec_t;

  vec_t vt [12];

  initial begin
    int ndone, cyc;
    vt[0]  = '{0, 0, 0,  0,  1,  100,  200,  0, 0, 20, 4};
    vt[1]  = '{0, 0, 19, 38, 39, 3900, 4000, 0, 1, 20, 4};
    vt[2]  = '{0, 1, 0,  0,  39, 100,  4000, 0, 0, 20, 4};
    vt[3]  = '{0, 1, 19, 19, 20, 2000, 2100, 0, 1, 20, 4};
    vt[4]  = '{3, 1, 0,  0,  4,  100,  500,  0, 0, 3,  4};
    vt[5]  = '{3, 1, 1,  1,  3,  200,  400,  0, 0, 3,  4};
    vt[6]  = '{3, 1, 2,  2,  2,  300,  0,    1, 1, 3,  4};
    vt[7]  = '{3, 0, 2,  4,  4,  500,  0,    1, 1, 3,  4};
    vt[8]  = '{1, 0, 5,  10, 11, 1100, 1200, 0, 0, 20, 3};
    vt[9]  = '{1, 1, 19, 19, 20, 2000, 2100, 0, 1, 20, 3};
    vt[10] = '{2, 1, 7,  7,  32, 800,  3300, 0, 0, 20, 5};
    vt[11] = '{2, 0, 19, 38, 39, 3900, 4000, 0, 1, 20, 5};

    rst = '1; start = '0; order_r = '0; m_ready = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("reset cfg%0d load", g),  load_w[g],  0);
      chk($sformatf("reset cfg%0d valid", g), valid_w[g], 0);
      chk($sformatf("reset cfg%0d busy", g),  busy_w[g],  0);
      chk($sformatf("reset cfg%0d done", g),  done_w[g],  0);
      chk($sformatf("reset cfg%0d addr", g),  {a1_w[g], a2_w[g]}, 0);
      chk($sformatf("reset cfg%0d data", g),  (d1_w[g] | d2_w[g]) != 0, 0);
      chk($sformatf("reset cfg%0d flags", g), {single_w[g], last_w[g], mode_w[g]}, 0);
    end
    rst = '0;
    m_ready = '1;

    for (int i = 0; i < 12; i++) begin
      run(vt[i].g, vt[i].ord, -1, 0, -1);
      chk($sformatf("vec%0d beats", i), nbeats, vt[i].nb);
      chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d addr1", i), cap_a1[vt[i].beat], vt[i].a1);
      chk($sformatf("vec%0d addr2", i), cap_a2[vt[i].beat], vt[i].a2);
      chk($sformatf("vec%0d data1", i), cap_d1[vt[i].beat], vt[i].d1);
      chk($sformatf("vec%0d data2", i), cap_d2[vt[i].beat], vt[i].d2);
      chk($sformatf("vec%0d single", i), cap_s[vt[i].beat], vt[i].s);
      chk($sformatf("vec%0d last", i), cap_l[vt[i].beat], vt[i].l);
      check_beats(vt[i].g, vt[i].ord, 1'b1);
    end

    // downstream stall of 5 cycles on beat 3
    run(0, 0, 3, 5, -1);
    chk("stall beat3 data1", cap_d1[3], 700);
    chk("stall beat3 data2", cap_d2[3], 800);
    chk("stall beat3 addr", cap_a1[3] * 64 + cap_a2[3], 6 * 64 + 7);
    chk("stall beat3 interval", acc_cyc[3] - acc_cyc[2], 3 + 5);
    check_beats(0, 0, 1'b0);

    // stray start while beat 2 is held
    run(0, 1, -1, 0, 2);
    check_beats(0, 1, 1'b1);

    // reset one cycle after beat 7 is accepted
    @(negedge clk);
    start[0] = 1'b1; order_r[0] = 1'b0; m_ready[0] = 1'b1;
    nbeats = 0; cyc = 0;
    while (nbeats < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start[0] = 1'b0;
      if (valid_w[0]) nbeats++;
    end
    chk("pre-reset beats accepted", nbeats, 8);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midrst valid", valid_w[0], 0);
    chk("midrst busy", busy_w[0], 0);
    chk("midrst done", done_w[0], 0);
    chk("midrst load", load_w[0], 0);
    chk("midrst addr", {a1_w[0], a2_w[0]}, 0);
    chk("midrst data", (d1_w[0] | d2_w[0]) != 0, 0);
    chk("midrst flags", {single_w[0], last_w[0]}, 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) ndone++;
    end
    chk("midrst no done/busy", ndone, 0);
    run(0, 0, -1, 0, -1);
    chk("post-reset beat0 data1", cap_d1[0], 100);
    chk("post-reset beat0 data2", cap_d2[0], 200);
    chk("post-reset latency", lat, 4);
    check_beats(0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
